// File: rtl/spu_pipes.sv
`default_nettype none
// ============================================================================
// Module   : spu_pipes
// Purpose  : Dual-issue SPU-style execution core. An even pipe (halfword
//            immediate load, add, subtract-from-immediate, logical/arithmetic
//            halfword shifts) and an odd pipe (quadword byte rotate, relative
//            branch) share a 128 x 128-bit register file.
//            Instruction words use big-endian bit numbering: architectural
//            bit 0 is port bit 31.
//            Timing for a pair sampled at edge E0:
//              E0   : instruction words and pc registered
//              E0+1 : result / branch registered (operands read this cycle)
//              E0+2 : destination register written
// Ports    : clk          - rising-edge clock
//            reset        - asynchronous active-low reset
//            instr_even   - even-pipe instruction word
//            instr_odd    - odd-pipe instruction word
//            pc           - word address of the instruction pair
//            pc_wb        - branch target, valid while branch_taken is high
//            branch_taken - one-cycle pulse per executed br
// Revision : 1.0 - initial release
// ============================================================================
module spu_pipes (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_even,
    input  logic [31:0] instr_odd,
    input  logic [7:0]  pc,
    output logic [7:0]  pc_wb,
    output logic        branch_taken
);

    // Opcodes, MSB-aligned. nop/lnop are not listed: like every unknown
    // opcode they fall through the decoders as "no write, no branch".
    localparam logic [8:0]  c_OP_ILH    = 9'b010000011;
    localparam logic [10:0] c_OP_AH     = 11'b00011001000;
    localparam logic [7:0]  c_OP_SFHI   = 8'b00001101;
    localparam logic [10:0] c_OP_ROTHM  = 11'b00001011101;
    localparam logic [10:0] c_OP_ROTMAH = 11'b00001011110;
    localparam logic [10:0] c_OP_ROTQBY = 11'b00111011100;
    localparam logic [8:0]  c_OP_BR     = 9'b001100100;

    // ------------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------------
    logic [127:0] regs [0:127];

    // ------------------------------------------------------------------------
    // Stage 1: sampled instruction pair
    // ------------------------------------------------------------------------
    logic [31:0] r_ex_even;
    logic [31:0] r_ex_odd;
    logic [7:0]  r_ex_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_even <= '0;
            r_ex_odd  <= '0;
            r_ex_pc   <= '0;
        end else begin
            r_ex_even <= instr_even;
            r_ex_odd  <= instr_odd;
            r_ex_pc   <= pc;
        end
    end

    // ------------------------------------------------------------------------
    // Even pipe
    // ------------------------------------------------------------------------
    logic [127:0] w_e_a;
    logic [127:0] w_e_b;
    logic [15:0]  w_e_i16;
    logic [15:0]  w_e_i10_sext;

    assign w_e_a        = regs[r_ex_even[13:7]];
    assign w_e_b        = regs[r_ex_even[20:14]];
    assign w_e_i16      = r_ex_even[22:7];
    assign w_e_i10_sext = {{6{r_ex_even[23]}}, r_ex_even[23:14]};

    logic [127:0] w_ah_res;
    logic [127:0] w_sfhi_res;
    logic [127:0] w_rothm_res;
    logic [127:0] w_rotmah_res;

    // All even-pipe arithmetic is lane-independent, so the eight halfwords
    // are built identically regardless of their position in the quadword.
    for (genvar g = 0; g < 8; g++) begin : g_lane
        logic [15:0] w_a;
        logic [15:0] w_b;
        logic [4:0]  w_cnt;

        assign w_a = w_e_a[16*g +: 16];
        assign w_b = w_e_b[16*g +: 16];
        // (0 - rb) & 0x1F only depends on the low five bits of rb.
        assign w_cnt = 5'd0 - w_b[4:0];

        assign w_ah_res[16*g +: 16]    = w_a + w_b;
        assign w_sfhi_res[16*g +: 16]  = w_e_i10_sext - w_a;
        // Counts of 16..31 shift every bit out.
        assign w_rothm_res[16*g +: 16] = w_cnt[4] ? 16'd0 : (w_a >> w_cnt[3:0]);
        assign w_rotmah_res[16*g +: 16] = w_cnt[4] ? {16{w_a[15]}}
                                        : $unsigned($signed(w_a) >>> w_cnt[3:0]);
    end

    logic         w_e_we;
    logic [127:0] w_e_res;

    always_comb begin
        w_e_we  = 1'b0;
        w_e_res = '0;
        if (r_ex_even[31:23] == c_OP_ILH) begin
            w_e_we  = 1'b1;
            w_e_res = {8{w_e_i16}};
        end else if (r_ex_even[31:21] == c_OP_AH) begin
            w_e_we  = 1'b1;
            w_e_res = w_ah_res;
        end else if (r_ex_even[31:24] == c_OP_SFHI) begin
            w_e_we  = 1'b1;
            w_e_res = w_sfhi_res;
        end else if (r_ex_even[31:21] == c_OP_ROTHM) begin
            w_e_we  = 1'b1;
            w_e_res = w_rothm_res;
        end else if (r_ex_even[31:21] == c_OP_ROTMAH) begin
            w_e_we  = 1'b1;
            w_e_res = w_rotmah_res;
        end
    end

    // ------------------------------------------------------------------------
    // Odd pipe
    // ------------------------------------------------------------------------
    logic [127:0] w_o_a;
    logic [3:0]   w_o_cnt;
    logic [6:0]   w_o_sh;
    logic [127:0] w_o_rot;

    assign w_o_a   = regs[r_ex_odd[13:7]];
    // Byte count lives in the low nibble of the most significant word of rb.
    assign w_o_cnt = regs[r_ex_odd[20:14]][99:96];
    assign w_o_sh  = {w_o_cnt, 3'b000};
    // Byte 0 is the MSB, so a left rotate moves bytes toward the MSB end.
    // A zero count gives a 128-bit right shift, which yields zero.
    assign w_o_rot = (w_o_a << w_o_sh) | (w_o_a >> (8'd128 - {1'b0, w_o_sh}));

    logic         w_o_we;
    logic [127:0] w_o_res;
    logic         w_o_br;
    logic [7:0]   w_o_tgt;

    always_comb begin
        w_o_we  = 1'b0;
        w_o_res = '0;
        w_o_br  = 1'b0;
        w_o_tgt = r_ex_pc + r_ex_odd[14:7];
        if (r_ex_odd[31:21] == c_OP_ROTQBY) begin
            w_o_we  = 1'b1;
            w_o_res = w_o_rot;
        end else if (r_ex_odd[31:23] == c_OP_BR) begin
            w_o_br  = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: registered results and branch
    // ------------------------------------------------------------------------
    logic         r_wb_we_even;
    logic [6:0]   r_wb_rt_even;
    logic [127:0] r_wb_res_even;
    logic         r_wb_we_odd;
    logic [6:0]   r_wb_rt_odd;
    logic [127:0] r_wb_res_odd;
    logic         r_br_taken;
    logic [7:0]   r_pc_wb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_we_even  <= 1'b0;
            r_wb_rt_even  <= '0;
            r_wb_res_even <= '0;
            r_wb_we_odd   <= 1'b0;
            r_wb_rt_odd   <= '0;
            r_wb_res_odd  <= '0;
            r_br_taken    <= 1'b0;
            r_pc_wb       <= '0;
        end else begin
            r_wb_we_even  <= w_e_we;
            r_wb_rt_even  <= r_ex_even[6:0];
            r_wb_res_even <= w_e_res;
            r_wb_we_odd   <= w_o_we;
            r_wb_rt_odd   <= r_ex_odd[6:0];
            r_wb_res_odd  <= w_o_res;
            r_br_taken    <= w_o_br;
            // Target holds its last value between branches.
            if (w_o_br) begin
                r_pc_wb <= w_o_tgt;
            end
        end
    end

    assign branch_taken = r_br_taken;
    assign pc_wb        = r_pc_wb;

    // ------------------------------------------------------------------------
    // Write-back. The odd write is issued last so it wins on a shared rt.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 128; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (r_wb_we_even) begin
                regs[r_wb_rt_even] <= r_wb_res_even;
            end
            if (r_wb_we_odd) begin
                regs[r_wb_rt_odd] <= r_wb_res_odd;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spu_pipes.sv
`default_nettype none
// ============================================================================
// Module   : tb_spu_pipes
// Purpose  : Self-checking bench for spu_pipes. A reference model with its
//            own register file and pending-write list predicts register
//            contents and branch outputs; expectations are queued when a
//            pair is issued and compared in the cycle the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spu_pipes;

    localparam logic [8:0]  c_OP_ILH    = 9'b010000011;
    localparam logic [10:0] c_OP_AH     = 11'b00011001000;
    localparam logic [7:0]  c_OP_SFHI   = 8'b00001101;
    localparam logic [10:0] c_OP_ROTHM  = 11'b00001011101;
    localparam logic [10:0] c_OP_ROTMAH = 11'b00001011110;
    localparam logic [10:0] c_OP_NOP    = 11'b01000000001;
    localparam logic [10:0] c_OP_ROTQBY = 11'b00111011100;
    localparam logic [8:0]  c_OP_BR     = 9'b001100100;
    localparam logic [10:0] c_OP_LNOP   = 11'b00000000001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_even;
    logic [31:0] instr_odd;
    logic [7:0]  pc;
    logic [7:0]  pc_wb;
    logic        branch_taken;

    always #5 clk = ~clk;

    spu_pipes dut (
        .clk          (clk),
        .reset        (reset),
        .instr_even   (instr_even),
        .instr_odd    (instr_odd),
        .pc           (pc),
        .pc_wb        (pc_wb),
        .branch_taken (branch_taken)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cnt   = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int cyc; logic [6:0] rt; logic [127:0] val; } wr_t;
    typedef struct { int cyc; bit is_reg; logic [6:0] rt; logic [127:0] val;
                     logic br; logic [7:0] pcw; } exp_t;

    logic [127:0] m_regs [128];
    wr_t          pend[$];
    exp_t         sb[$];
    logic [7:0]   m_pcw;

    // Register value as visible during cycle count t.
    function automatic logic [127:0] model_read(input logic [6:0] r, input int t);
        logic [127:0] v = m_regs[r];
        foreach (pend[i]) if (pend[i].cyc <= t && pend[i].rt == r) v = pend[i].val;
        return v;
    endfunction

    function automatic void exec_even(input logic [31:0] w, input int t, output bit we,
                                      output logic [6:0] rt, output logic [127:0] res);
        logic [127:0] a, b;
        logic [15:0]  ah, bh, nb, r;
        int           s;
        we = 1'b0; rt = w[6:0]; res = '0;
        a = model_read(w[13:7], t);
        b = model_read(w[20:14], t);
        if (w[31:23] == c_OP_ILH || w[31:21] == c_OP_AH || w[31:24] == c_OP_SFHI ||
            w[31:21] == c_OP_ROTHM || w[31:21] == c_OP_ROTMAH) we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ah = a[127-16*i -: 16];
            bh = b[127-16*i -: 16];
            nb = 16'd0 - bh;
            s  = int'(nb & 16'h001F);
            r  = '0;
            if (w[31:23] == c_OP_ILH)         r = w[22:7];
            else if (w[31:21] == c_OP_AH)     r = ah + bh;
            else if (w[31:24] == c_OP_SFHI)   r = {{6{w[23]}}, w[23:14]} - ah;
            else if (w[31:21] == c_OP_ROTHM)  r = (s >= 16) ? 16'h0 : ah >> s;
            else if (w[31:21] == c_OP_ROTMAH) r = (s >= 16) ? {16{ah[15]}} : $unsigned($signed(ah) >>> s);
            res[127-16*i -: 16] = r;
        end
    endfunction

    function automatic void exec_odd(input logic [31:0] w, input int t, input logic [7:0] p,
                                     output bit we, output logic [6:0] rt, output logic [127:0] res,
                                     output bit br, output logic [7:0] tgt);
        logic [127:0] a, b;
        logic [31:0]  word0;
        int           n;
        we = 1'b0; br = 1'b0; rt = w[6:0]; res = '0; tgt = '0;
        if (w[31:21] == c_OP_ROTQBY) begin
            a = model_read(w[13:7], t);
            b = model_read(w[20:14], t);
            word0 = b[127:96];
            n = int'(word0[3:0]);
            for (int k = 0; k < 16; k++) res[127-8*k -: 8] = a[127-8*((k+n)%16) -: 8];
            we = 1'b1;
        end else if (w[31:23] == c_OP_BR) begin
            br  = 1'b1;
            tgt = p + w[14:7];
        end
    endfunction

    function automatic logic [31:0] rr(input logic [10:0] op, input logic [6:0] rb,
                                       input logic [6:0] ra, input logic [6:0] rt);
        return {op, rb, ra, rt};
    endfunction
    function automatic logic [31:0] ri10(input logic [7:0] op, input logic [9:0] i10,
                                         input logic [6:0] ra, input logic [6:0] rt);
        return {op, i10, ra, rt};
    endfunction
    function automatic logic [31:0] ri16(input logic [8:0] op, input logic [15:0] i16,
                                         input logic [6:0] rt);
        return {op, i16, rt};
    endfunction

    // One clock: advance, retire model writes, then compare due expectations.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cnt++;
        while (pend.size() > 0 && pend[0].cyc <= cnt) begin
            m_regs[pend[0].rt] = pend[0].val;
            pend.delete(0);
        end
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc <= cnt) begin
            e = sb[0];
            sb.delete(0);
            if (e.is_reg) begin
                chk($sformatf("reg%0d@%0d", e.rt, e.cyc), dut.regs[e.rt], e.val);
            end else begin
                chk($sformatf("br_taken@%0d", e.cyc), {127'b0, branch_taken}, {127'b0, e.br});
                chk($sformatf("pc_wb@%0d", e.cyc), {120'b0, pc_wb}, {120'b0, e.pcw});
            end
        end
    endtask

    task automatic issue(input logic [31:0] ie, input logic [31:0] io, input logic [7:0] p);
        bit           we_e, we_o, br;
        logic [6:0]   rt_e, rt_o;
        logic [127:0] re, ro;
        logic [7:0]   tgt;
        int           c = cnt;
        instr_even = ie;
        instr_odd  = io;
        pc         = p;
        exec_even(ie, c + 1, we_e, rt_e, re);
        exec_odd(io, c + 1, p, we_o, rt_o, ro, br, tgt);
        if (we_e) pend.push_back('{cyc: c + 3, rt: rt_e, val: re});
        if (we_o) pend.push_back('{cyc: c + 3, rt: rt_o, val: ro});
        if (br) m_pcw = tgt;
        sb.push_back('{cyc: c + 2, is_reg: 1'b0, rt: 7'd0, val: 128'd0, br: br, pcw: m_pcw});
        if (we_e && !(we_o && rt_o == rt_e))
            sb.push_back('{cyc: c + 3, is_reg: 1'b1, rt: rt_e, val: model_read(rt_e, c + 3), br: 1'b0, pcw: 8'd0});
        if (we_o)
            sb.push_back('{cyc: c + 3, is_reg: 1'b1, rt: rt_o, val: model_read(rt_o, c + 3), br: 1'b0, pcw: 8'd0});
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) issue(32'h0, 32'h0, 8'h00);
    endtask

    task automatic drain();
        idle(1);
        for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
    endtask

    function automatic logic [31:0] lnop();
        return rr(c_OP_LNOP, 7'd0, 7'd0, 7'd0);
    endfunction
    function automatic logic [31:0] nop();
        return rr(c_OP_NOP, 7'd0, 7'd0, 7'd0);
    endfunction

    initial begin
        foreach (m_regs[i]) m_regs[i] = '0;
        m_pcw      = 8'h00;
        instr_even = '0;
        instr_odd  = '0;
        pc         = '0;
        reset      = 1'b1;
        #1 reset   = 1'b0;
        tick();
        tick();
        chk("rst_reg0", dut.regs[0], 128'd0);
        chk("rst_reg127", dut.regs[127], 128'd0);
        chk("rst_br", {127'b0, branch_taken}, 128'd0);
        chk("rst_pcwb", {120'b0, pc_wb}, 128'd0);
        reset = 1'b1;

        // Halfword add
        issue(ri16(c_OP_ILH, 16'h1F0F, 7'd1), lnop(), 8'h00);
        issue(ri16(c_OP_ILH, 16'h52F0, 7'd2), lnop(), 8'h01);
        idle(2);
        issue(rr(c_OP_AH, 7'd2, 7'd1, 7'd3), lnop(), 8'h02);
        idle(2);
        // Subtract from immediate
        issue(ri16(c_OP_ILH, 16'h0003, 7'd4), lnop(), 8'h03);
        idle(2);
        issue(ri10(c_OP_SFHI, 10'd0, 7'd4, 7'd6), lnop(), 8'h04);
        idle(2);
        // Dual issue: rothm and rotqby written at the same edge
        issue(rr(c_OP_ROTHM, 7'd6, 7'd3, 7'd5), rr(c_OP_ROTQBY, 7'd4, 7'd3, 7'd7), 8'h05);
        // Arithmetic shift
        issue(ri16(c_OP_ILH, 16'h8000, 7'd8), lnop(), 8'h06);
        idle(2);
        issue(rr(c_OP_ROTMAH, 7'd6, 7'd8, 7'd9), lnop(), 8'h07);
        // Shift count of 16
        issue(ri16(c_OP_ILH, 16'hFFF0, 7'd11), lnop(), 8'h08);
        idle(2);
        issue(rr(c_OP_ROTHM, 7'd11, 7'd3, 7'd12), lnop(), 8'h09);
        // Branches, including address wrap
        issue(nop(), ri16(c_OP_BR, 16'h0005, 7'd0), 8'h10);
        idle(2);
        issue(nop(), ri16(c_OP_BR, 16'h0003, 7'd0), 8'hFE);
        idle(1);
        // Same destination in both pipes: odd wins
        issue(ri16(c_OP_ILH, 16'hAAAA, 7'd20), rr(c_OP_ROTQBY, 7'd4, 7'd3, 7'd20), 8'h20);
        // Stale read one cycle later, fresh read two cycles later
        issue(ri16(c_OP_ILH, 16'h1111, 7'd21), lnop(), 8'h21);
        issue(rr(c_OP_AH, 7'd21, 7'd21, 7'd22), lnop(), 8'h22);
        issue(rr(c_OP_AH, 7'd21, 7'd21, 7'd23), lnop(), 8'h23);
        // $0 is an ordinary register; unlisted opcodes write nothing
        issue(ri16(c_OP_ILH, 16'h0042, 7'd0), 32'hFFFF_FFFF, 8'h24);
        idle(2);
        issue(rr(c_OP_AH, 7'd0, 7'd0, 7'd24), lnop(), 8'h25);
        drain();

        chk("ah_71ff", dut.regs[3], {8{16'h71FF}});
        chk("sfhi_fffd", dut.regs[6], {8{16'hFFFD}});
        chk("rothm_0e3f", dut.regs[5], {8{16'h0E3F}});
        chk("rotqby_ff71", dut.regs[7], {8{16'hFF71}});
        chk("rotmah_f000", dut.regs[9], {8{16'hF000}});
        chk("rothm_cnt16", dut.regs[12], 128'd0);
        chk("stale_read", dut.regs[22], 128'd0);
        chk("fresh_read", dut.regs[23], {8{16'h2222}});
        chk("reg0_use", dut.regs[24], {8{16'h0084}});
        chk("unlisted_nowr", dut.regs[127], 128'd0);

        // Reset with an ilh and a br in flight
        instr_even = ri16(c_OP_ILH, 16'h1234, 7'd10);
        instr_odd  = ri16(c_OP_BR, 16'h0001, 7'd0);
        pc         = 8'h30;
        tick();
        instr_even = '0;
        instr_odd  = '0;
        pc         = '0;
        @(posedge clk);
        cnt++;
        #1;
        chk("inflight_br", {127'b0, branch_taken}, {127'b0, 1'b1});
        chk("inflight_pcwb", {120'b0, pc_wb}, {120'b0, 8'h31});
        #1 reset = 1'b0;
        #1;
        chk("arst_br", {127'b0, branch_taken}, 128'd0);
        chk("arst_pcwb", {120'b0, pc_wb}, 128'd0);
        chk("arst_reg10", dut.regs[10], 128'd0);
        chk("arst_reg3", dut.regs[3], 128'd0);
        @(negedge clk);
        tick();
        tick();
        chk("rst_hold_reg10", dut.regs[10], 128'd0);
        reset = 1'b1;
        foreach (m_regs[i]) m_regs[i] = '0;
        pend.delete();
        sb.delete();
        m_pcw = 8'h00;
        tick();
        chk("post_rst_reg10", dut.regs[10], 128'd0);

        // Normal operation after release
        issue(ri16(c_OP_ILH, 16'h5678, 7'd10), lnop(), 8'h40);
        issue(ri16(c_OP_ILH, 16'h0101, 7'd13), lnop(), 8'h41);
        idle(2);
        issue(rr(c_OP_AH, 7'd13, 7'd10, 7'd14), ri16(c_OP_BR, 16'h0010, 7'd0), 8'h42);
        drain();
        chk("post_rst_ah", dut.regs[14], {8{16'h5779}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spu_pipes.md
SPU_PIPES -- requirements
Module: spu_pipes

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 instr_even  input  32, bits [0:31] (bit 0 = MSB)  even-pipe instruction word, sampled every rising edge.
REQ-005 instr_odd  input  32, bits [0:31]  odd-pipe instruction word, sampled with instr_even.
REQ-006 pc  input  8  word address of the instruction pair, sampled with the instructions.
REQ-007 pc_wb  output  8  branch target address.
REQ-008 branch_taken  output  1  one-cycle pulse; pc_wb is valid while it is high.
REQ-009 Internal register file SHALL be 128 x 128-bit, array named regs, indexed by register number, hierarchically readable by the bench.

Function
REQ-010 Field decode (bit 0 = MSB):
- RR: opcode [0:10], rb [11:17], ra [18:24], rt [25:31].
- RI10: opcode [0:7], I10 [8:17], ra, rt.
- RI16: opcode [0:8], I16 [9:24], rt.
REQ-011 Even pipe SHALL implement the following (all halfword ops act on all 8 halfwords):
- ilh, RI16 010000011: each halfword = I16.
- ah, RR 00011001000: ra + rb mod 2^16.
- sfhi, RI10 00001101: sext(I10) - ra mod 2^16.
- rothm, RR 00001011101: s = (0 - rb_h) & 0x1F; result = ra_h logical right by s, or 0 if s >= 16.
- rotmah, RR 00001011110: same s; ra_h arithmetic right by s, or all sign bits if s >= 16.
- nop, RR 01000000001: no write.
REQ-012 Odd pipe SHALL implement the following:
- rotqby, RR 00111011100: rt = 128-bit ra rotated left by (rb[28:31] of word 0) bytes; byte 0 is the most significant.
- br, RI16 001100100: branch, pc_wb = (pc + I16)[7:0]; no register write.
- lnop, RR 00000000001: no write.
REQ-013 An all-zero word and any unlisted opcode in either pipe SHALL be a no-op: no register write, no branch.
REQ-014 Pipeline timing, for an instruction sampled at edge E0:
- E0: the instruction and pc are registered.
- Cycle after E0: ra and rb are read combinationally from regs.
- E0+1: the result is registered.
- E0+2: rt is written.
REQ-015 An instruction sampled at E0+2 or later SHALL see the new rt value; there is no forwarding or hazard detection, and an earlier reader gets the stale value.
REQ-016 br SHALL drive branch_taken=1 and pc_wb to the target during the cycle after E0+1 (registered at E0+1), for exactly one cycle per br.
REQ-017 When no branch is in flight, branch_taken SHALL be 0 and pc_wb SHALL hold its last value.
REQ-018 Both pipes SHALL be able to write in the same cycle; if both write the same rt, the odd-pipe result SHALL win.
REQ-019 Source operands SHALL be read from regs as held at the start of the read cycle; a write at the same edge is visible from the next cycle.
REQ-020 Register $0 SHALL be an ordinary register with no special behaviour.

Reset
REQ-021 While reset=0, all 128 registers SHALL be 0, the pipeline stages SHALL hold no-ops, branch_taken SHALL be 0 and pc_wb SHALL be 0x00, immediately and independent of clk.
REQ-022 Instructions in flight when reset asserts SHALL be discarded and never write regs or branch.
REQ-023 Sampling SHALL resume at the first rising edge after reset returns to 1.

Verification
REQ-024 Halfword add: ilh $1,0x1F0F; ilh $2,0x52F0; two idle cycles; ah $3,$1,$2 -> every halfword of $3 = 0x71FF.
REQ-025 Subtract from immediate: ilh $4,0x0003; then sfhi $6,$4,0 -> every halfword of $6 = 0xFFFD.
REQ-026 Halfword shifts:
- rothm $5,$3,$6 -> $5 halfwords 0x0E3F.
- ilh $8,0x8000; then rotmah $9,$8,$6 -> $9 halfwords 0xF000.
- rothm with rb halfwords 0xFFF0 (count 16) -> result 0.
REQ-027 Dual issue: rothm $5,$3,$6 with rotqby $7,$3,$4 in the same pair -> $5 halfwords 0x0E3F and $7 halfwords 0xFF71; both written at the same edge.
REQ-028 Branch: pc=0x10 with odd br I16=0x0005 -> branch_taken high for exactly one cycle with pc_wb=0x15; with pc=0xFE and I16=0x0003 -> pc_wb=0x01 (wrap).
REQ-029 Reset mid-operation: issue ilh $10,0x1234, then assert reset=0 before its write edge -> $10 stays 0 and branch_taken is 0 immediately; after release, new instructions execute normally.
